p_ng_banked: RTL and testbench
==============================

Name: p_ng_banked

Overview:
- Next-generation ping/pang/pong packet buffer. Stores one packet from the snooper and serves it to the filter CPU.
- Memory is split into LANES word-interleaved banks, so writes and reads are LANES words wide at any word address, including unaligned addresses, with wrap-around.
- Adds an ownership state machine (EMPTY/FILLING/READY/READING), done handshakes, a latched saturating byte length, a read-valid strobe and a sticky protocol-error flag.
- Sits between the snooper and the CPU, one instance per p_ng slot.

Parameters:
- ADDR_WIDTH, 10: word-address width; buffer holds 2^ADDR_WIDTH words.
- WORD_WIDTH, 32: bits per memory word.
- SN_FWD_WIDTH, 64: write and read data width. Must equal LANES*WORD_WIDTH.
- LANES, 2: number of banks. Power of two, at least 2, and no greater than 2^ADDR_WIDTH.
- BUF_IN, 0: if 1, register all inputs for one cycle.
- BUF_OUT, 0: if 1, register rd_data and rd_valid for one cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write LANES words starting at wr_addr
- wr_addr  in  ADDR_WIDTH  word address of lane 0 of wr_data
- wr_data  in  SN_FWD_WIDTH  MSB word goes to wr_addr; the next word down goes to wr_addr+1; and so on
- byte_inc  in  $clog2(SN_FWD_WIDTH/8)+1  valid bytes in this write
- wr_done  in  1  snooper finished the packet
- rd_en  in  1  read LANES words starting at rd_addr
- rd_addr  in  ADDR_WIDTH  word address of the MSB word of rd_data
- rd_done  in  1  CPU finished with the packet
- rd_data  out  SN_FWD_WIDTH  read data, same word ordering as wr_data
- rd_valid  out  1  rd_data valid this cycle
- byte_length  out  33  accumulated packet byte count
- state  out  2  buffer state: 00 EMPTY, 01 FILLING, 10 READY, 11 READING
- error  out  1  sticky protocol violation

Behaviour:
- Reset (rst=1 at a clock edge): state=EMPTY, byte_length=0, error=0, rd_valid=0, rd_data=0, and all BUF_IN/BUF_OUT registers cleared. Memory contents are not altered.
- Reset mid-operation:
  - Any in-flight read is cancelled; rd_valid stays 0.
  - An in-flight write (BUF_IN=1) is discarded.
- All FSM and length logic below acts on the internal signals, i.e. after BUF_IN delay.
- Bank mapping: word address a lives in bank (a mod LANES) at row a/LANES.
- Lane k (k=0 is the MSB word) of a write or read targets address (addr+k) mod 2^ADDR_WIDTH. Example: LANES=2, wr_addr=1023, ADDR_WIDTH=10 writes words 1023 and 0.
- Each bank is a simple dual-port RAM: one write port, one read port, 1-cycle synchronous read.
- If the same address is read and written in the same cycle, the read returns the old data (read-first).
- FSM transitions:
  - EMPTY: wr_en -> FILLING, with byte_length set to byte_inc. wr_done alone -> READY with byte_length=0.
  - FILLING: wr_en adds byte_inc to byte_length. wr_done -> READY. If wr_en and wr_done occur in the same cycle, the write and its byte_inc are both included.
  - READY: rd_en -> READING. rd_done -> EMPTY (packet dropped).
  - READING: rd_done -> EMPTY. A rd_en in the same cycle as rd_done is still performed.
  - byte_length holds its value in READY and READING. It clears on the EMPTY->FILLING write and on reset, and holds in EMPTY otherwise.
- Acceptance rules:
  - Writes are accepted only in EMPTY or FILLING.
  - Reads are accepted only in READY or READING.
  - A rejected wr_en or rd_en does not touch memory and does not assert rd_valid.
  - Any rejected wr_en or rd_en, wr_done outside EMPTY/FILLING, or rd_done outside READY/READING sets error. error stays set until rst.
- byte_inc values above SN_FWD_WIDTH/8 are clamped to SN_FWD_WIDTH/8. byte_length saturates at 2^33-1.
- Read latency: rd_valid and rd_data appear 1+BUF_IN+BUF_OUT cycles after rd_en.
- rd_data holds its last value when rd_valid=0.
- Write-to-read visibility: a read issued the cycle after a write's internal edge returns the new data.

Decomposition:
- Package p_ng_pkg holds:
  - the state encoding constants (ST_EMPTY, ST_FILLING, ST_READY, ST_READING);
  - a LANE_BITS=$clog2(LANES) constant helper;
  - a lane-rotate function that maps lane k and base address to a bank and row.
- Sub-module sdp_bank is a simple dual-port RAM with ADDR_WIDTH-LANE_BITS address bits and WORD_WIDTH data bits, instantiated LANES times.
- Rotation muxes and the FSM live in the top level.

Test Plan:
1. Nominal fill and read, defaults:
   - Stimulus: writes at addr 0, 2, 4 with data 64'hA0A1_A2A3_B0B1_B2B3 etc., byte_inc 8, 8, 5; then wr_done.
   - Response: state=READY, byte_length=21.
   - Then rd_en at addr 1 -> rd_valid one cycle later with data {word1, word2}.
2. Wrap-around:
   - Stimulus: write at addr 1023 with data 64'h1111_1111_2222_2222.
   - Response: word 1023=32'h11111111 and word 0=32'h22222222; a read at 1023 returns the same 64 bits.
3. Protocol errors:
   - rd_en in EMPTY -> error=1, rd_valid stays 0, state unchanged.
   - wr_en in READY -> memory unchanged, error=1.
   - rst -> error=0.
4. Simultaneous events:
   - wr_en plus wr_done in FILLING with byte_inc 3 -> byte_length includes the 3, state=READY.
   - rd_en plus rd_done in READING -> read completes, state=EMPTY.
   - wr_done in EMPTY -> READY with byte_length=0.
5. Pipelining: with BUF_IN=1 and BUF_OUT=1, rd_valid appears exactly 3 cycles after rd_en. Run back-to-back reads at addrs 0, 2, 4 and check the data order.
6. Reset mid-read and saturation:
   - rst one cycle after rd_en (BUF_OUT=1) -> no rd_valid; state=EMPTY; memory is preserved, verified by a refill-free read after a forced wr_done.
   - Saturation of byte_length is checked via a forced near-max value.

Source files
------------

// File: rtl/p_ng_pkg.sv
// Shared types and helpers for the banked ping/pang/pong packet buffer.
// Holds the ownership state encoding and the lane-to-bank address map.
package p_ng_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_FILLING = 2'b01,
    ST_READY   = 2'b10,
    ST_READING = 2'b11
  } state_t;

  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] row;
  } lane_loc_t;

  function automatic int unsigned lane_bits(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

  // Lane k of an access based at 'base' lands on word (base+k) mod 2^addr_width,
  // which sits in bank (word mod lanes) at row (word / lanes).
  function automatic lane_loc_t lane_rotate(input logic [31:0] k,
                                            input logic [31:0] base,
                                            input int unsigned addr_width,
                                            input int unsigned lanes,
                                            input int unsigned lb);
    logic [31:0] word;
    lane_loc_t   loc;
    word     = (base + k) & ((32'd1 << addr_width) - 32'd1);
    loc.bank = word & (lanes - 32'd1);
    loc.row  = word >> lb;
    return loc;
  endfunction

endpackage

// File: rtl/p_ng_banked_if.sv
// Snooper/CPU-facing bus of one p_ng slot: write side, read side and status.
// The master is the snooper+CPU pair, the slave is the buffer.
interface p_ng_banked_if #(
  parameter int ADDR_WIDTH   = 10,
  parameter int SN_FWD_WIDTH = 64
);
  localparam int BIW = $clog2(SN_FWD_WIDTH / 8) + 1;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [SN_FWD_WIDTH-1:0] wr_data;
  logic [BIW-1:0]          byte_inc;
  logic                    wr_done;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_done;
  logic [SN_FWD_WIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic [32:0]             byte_length;
  logic [1:0]              state;
  logic                    error;

  modport master (
    output wr_en, wr_addr, wr_data, byte_inc, wr_done, rd_en, rd_addr, rd_done,
    input  rd_data, rd_valid, byte_length, state, error
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, byte_inc, wr_done, rd_en, rd_addr, rd_done,
    output rd_data, rd_valid, byte_length, state, error
  );
endinterface

// File: rtl/sdp_bank.sv
// Simple dual-port RAM bank: one write port, one read port, 1-cycle read.
// Reading and writing the same row in one cycle returns the old word.
module sdp_bank #(
  parameter int ADDR_BITS  = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: the array is never reset so it maps onto block RAM; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/p_ng_banked.sv
// Banked p_ng packet buffer: LANES word-interleaved banks with rotation muxes,
// ownership FSM, saturating byte length and sticky protocol-error flag.
module p_ng_banked
  import p_ng_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int WORD_WIDTH   = 32,
  parameter int SN_FWD_WIDTH = 64,
  parameter int LANES        = 2,
  parameter int BUF_IN       = 0,
  parameter int BUF_OUT      = 0
) (
  input logic         clk,
  input logic         rst,
  p_ng_banked_if.slave bus
);

  localparam int LANE_BITS = lane_bits(LANES);
  localparam int ROW_W     = (ADDR_WIDTH > LANE_BITS) ? ADDR_WIDTH - LANE_BITS : 1;
  localparam int BYTES     = SN_FWD_WIDTH / 8;
  localparam int BIW       = $clog2(BYTES) + 1;

  logic                    in_wr_en, in_wr_done, in_rd_en, in_rd_done;
  logic [ADDR_WIDTH-1:0]   in_wr_addr, in_rd_addr;
  logic [SN_FWD_WIDTH-1:0] in_wr_data;
  logic [BIW-1:0]          in_byte_inc;

  if (BUF_IN != 0) begin : g_buf_in
    always_ff @(posedge clk) begin
      if (rst) begin
        in_wr_en    <= 1'b0;
        in_wr_addr  <= '0;
        in_wr_data  <= '0;
        in_byte_inc <= '0;
        in_wr_done  <= 1'b0;
        in_rd_en    <= 1'b0;
        in_rd_addr  <= '0;
        in_rd_done  <= 1'b0;
      end else begin
        in_wr_en    <= bus.wr_en;
        in_wr_addr  <= bus.wr_addr;
        in_wr_data  <= bus.wr_data;
        in_byte_inc <= bus.byte_inc;
        in_wr_done  <= bus.wr_done;
        in_rd_en    <= bus.rd_en;
        in_rd_addr  <= bus.rd_addr;
        in_rd_done  <= bus.rd_done;
      end
    end
  end else begin : g_no_buf_in
    assign in_wr_en    = bus.wr_en;
    assign in_wr_addr  = bus.wr_addr;
    assign in_wr_data  = bus.wr_data;
    assign in_byte_inc = bus.byte_inc;
    assign in_wr_done  = bus.wr_done;
    assign in_rd_en    = bus.rd_en;
    assign in_rd_addr  = bus.rd_addr;
    assign in_rd_done  = bus.rd_done;
  end

  // Ownership FSM, byte length and error flag.
  state_t      st_q;
  logic [32:0] len_q;
  logic        err_q;
  logic        wr_side, rd_side, wr_ok, rd_ok, proto_bad;
  logic [BIW-1:0] inc;
  logic [33:0] len_sum;
  logic [32:0] len_sat;

  assign wr_side   = (st_q == ST_EMPTY) || (st_q == ST_FILLING);
  assign rd_side   = (st_q == ST_READY) || (st_q == ST_READING);
  assign wr_ok     = in_wr_en && wr_side;
  assign rd_ok     = in_rd_en && rd_side;
  assign proto_bad = (in_wr_en && !wr_side) || (in_rd_en && !rd_side) ||
                     (in_wr_done && !wr_side) || (in_rd_done && !rd_side);
  assign inc       = (in_byte_inc > BIW'(BYTES)) ? BIW'(BYTES) : in_byte_inc;
  assign len_sum   = {1'b0, len_q} + 34'(inc);
  assign len_sat   = len_sum[33] ? '1 : len_sum[32:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_EMPTY;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (proto_bad) err_q <= 1'b1;
      case (st_q)
        ST_EMPTY: begin
          if (wr_ok) begin
            len_q <= 33'(inc);
            st_q  <= in_wr_done ? ST_READY : ST_FILLING;
          end else if (in_wr_done) begin
            len_q <= '0;
            st_q  <= ST_READY;
          end
        end
        ST_FILLING: begin
          if (wr_ok)      len_q <= len_sat;
          if (in_wr_done) st_q  <= ST_READY;
        end
        ST_READY: begin
          if (in_rd_done)  st_q <= ST_EMPTY;
          else if (rd_ok)  st_q <= ST_READING;
        end
        ST_READING: if (in_rd_done) st_q <= ST_EMPTY;
        default: st_q <= ST_EMPTY;
      endcase
    end
  end

  // Bank array and rotation muxes.
  logic [ROW_W-1:0]      bank_waddr [LANES];
  logic [WORD_WIDTH-1:0] bank_wdata [LANES];
  logic [ROW_W-1:0]      bank_raddr [LANES];
  logic [WORD_WIDTH-1:0] bank_rdata [LANES];
  logic [LANE_BITS-1:0]  rd_lo_q;
  logic                  rd_valid_s;
  logic [SN_FWD_WIDTH-1:0] rd_data_s;
  logic                  unused_loc;

  always_comb begin
    lane_loc_t loc;
    unused_loc = 1'b0;
    rd_data_s  = '0;
    for (int b = 0; b < LANES; b++) begin
      bank_waddr[b] = '0;
      bank_wdata[b] = '0;
      bank_raddr[b] = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      loc = lane_rotate(32'(k), 32'(in_wr_addr), ADDR_WIDTH, LANES, LANE_BITS);
      bank_waddr[loc.bank[LANE_BITS-1:0]] = loc.row[ROW_W-1:0];
      bank_wdata[loc.bank[LANE_BITS-1:0]] = in_wr_data[(LANES-1-k)*WORD_WIDTH +: WORD_WIDTH];
      unused_loc = unused_loc ^ (^(loc.bank >> LANE_BITS)) ^ (^(loc.row >> ROW_W));

      loc = lane_rotate(32'(k), 32'(in_rd_addr), ADDR_WIDTH, LANES, LANE_BITS);
      bank_raddr[loc.bank[LANE_BITS-1:0]] = loc.row[ROW_W-1:0];
      unused_loc = unused_loc ^ (^(loc.bank >> LANE_BITS)) ^ (^(loc.row >> ROW_W));

      // Unrotate with the low address bits captured alongside the read.
      loc = lane_rotate(32'(k), 32'(rd_lo_q), ADDR_WIDTH, LANES, LANE_BITS);
      rd_data_s[(LANES-1-k)*WORD_WIDTH +: WORD_WIDTH] = bank_rdata[loc.bank[LANE_BITS-1:0]];
      unused_loc = unused_loc ^ (^(loc.bank >> LANE_BITS)) ^ (^loc.row);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    sdp_bank #(
      .ADDR_BITS  (ROW_W),
      .DATA_WIDTH (WORD_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_ok),
      .waddr (bank_waddr[g]),
      .wdata (bank_wdata[g]),
      .re    (rd_ok),
      .raddr (bank_raddr[g]),
      .rdata (bank_rdata[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_s <= 1'b0;
      rd_lo_q    <= '0;
    end else begin
      rd_valid_s <= rd_ok;
      if (rd_ok) rd_lo_q <= in_rd_addr[LANE_BITS-1:0];
    end
  end

  logic                    rd_valid_o;
  logic [SN_FWD_WIDTH-1:0] rd_data_o;

  if (BUF_OUT != 0) begin : g_buf_out
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_valid_o <= 1'b0;
        rd_data_o  <= '0;
      end else begin
        rd_valid_o <= rd_valid_s;
        if (rd_valid_s) rd_data_o <= rd_data_s;
      end
    end
  end else begin : g_no_buf_out
    assign rd_valid_o = rd_valid_s;
    assign rd_data_o  = rd_data_s;
  end

  assign bus.rd_valid    = rd_valid_o;
  assign bus.rd_data     = rd_data_o;
  assign bus.byte_length = len_q;
  assign bus.state       = st_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_p_ng_banked.sv
// Drives an unbuffered and a fully buffered p_ng_banked with identical stimulus
// and checks both against a word-array reference model of the packet buffer.
module tb_p_ng_banked;

  localparam logic [63:0] MAXL = 64'h1_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  p_ng_banked_if #(.ADDR_WIDTH(10), .SN_FWD_WIDTH(64)) bus0 ();
  p_ng_banked_if #(.ADDR_WIDTH(10), .SN_FWD_WIDTH(64)) bus1 ();

  assign bus1.wr_en    = bus0.wr_en;
  assign bus1.wr_addr  = bus0.wr_addr;
  assign bus1.wr_data  = bus0.wr_data;
  assign bus1.byte_inc = bus0.byte_inc;
  assign bus1.wr_done  = bus0.wr_done;
  assign bus1.rd_en    = bus0.rd_en;
  assign bus1.rd_addr  = bus0.rd_addr;
  assign bus1.rd_done  = bus0.rd_done;

  p_ng_banked dut0 (.clk(clk), .rst(rst), .bus(bus0));
  p_ng_banked #(.BUF_IN(1), .BUF_OUT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [1024];
  int          st_m;
  logic [63:0] len_m;
  bit          err_m;
  int          rq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mread(input int a);
    return {mem_m[a % 1024], mem_m[(a + 1) % 1024]};
  endfunction

  task automatic model_reset();
    st_m = 0; len_m = 0; err_m = 0;
  endtask

  // Packet-buffer rules: 0 EMPTY, 1 FILLING, 2 READY, 3 READING.
  task automatic model_cycle(input bit we, input int wa, input logic [63:0] wd, input int bi,
                             input bit wdn, input bit re, input bit rdn);
    bit wside, rside, wok;
    logic [63:0] inc;
    wside = (st_m <= 1);
    rside = (st_m >= 2);
    wok   = we && wside;
    inc   = (bi > 8) ? 64'd8 : 64'(bi);
    if ((we && !wside) || (re && !rside) || (wdn && !wside) || (rdn && !rside)) err_m = 1;
    if (wok) begin
      mem_m[wa % 1024]       = wd[63:32];
      mem_m[(wa + 1) % 1024] = wd[31:0];
    end
    if (st_m == 0) begin
      if (wok) begin len_m = inc; st_m = wdn ? 2 : 1; end
      else if (wdn) begin len_m = 0; st_m = 2; end
    end else if (st_m == 1) begin
      if (wok) len_m = (len_m + inc > MAXL) ? MAXL : len_m + inc;
      if (wdn) st_m = 2;
    end else if (st_m == 2) begin
      if (rdn) st_m = 0;
      else if (re) st_m = 3;
    end else if (rdn) st_m = 0;
  endtask

  task automatic clear_inputs();
    bus0.wr_en = 0; bus0.wr_addr = 0; bus0.wr_data = 0; bus0.byte_inc = 0;
    bus0.wr_done = 0; bus0.rd_en = 0; bus0.rd_addr = 0; bus0.rd_done = 0;
  endtask

  task automatic op(input bit we, input int wa, input logic [63:0] wd, input int bi,
                    input bit wdn, input bit rdn);
    @(negedge clk);
    bus0.wr_en = we; bus0.wr_addr = 10'(wa); bus0.wr_data = wd; bus0.byte_inc = 4'(bi);
    bus0.wr_done = wdn; bus0.rd_en = 0; bus0.rd_done = rdn;
    model_cycle(we, wa, wd, bi, wdn, 1'b0, rdn);
    @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic settle(input string tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_state0"}, 64'(bus0.state), 64'(st_m));
    check({tag, "_len0"},   64'(bus0.byte_length), len_m);
    check({tag, "_err0"},   64'(bus0.error), 64'(err_m));
    check({tag, "_state1"}, 64'(bus1.state), 64'(st_m));
    check({tag, "_len1"},   64'(bus1.byte_length), len_m);
    check({tag, "_err1"},   64'(bus1.error), 64'(err_m));
  endtask

  // Issues reads from rq on consecutive cycles; each DUT must show rd_valid exactly
  // at its latency (1 unbuffered, 3 fully buffered) and nowhere else in the window.
  task automatic read_burst(input string tag, input bit rdn_last);
    logic [63:0] exp_q [$];
    bit          acc_q [$];
    int          n, lat, idx;
    bit          ev, rdn;
    logic        v;
    logic [63:0] dat;
    n = rq.size();
    for (int t = 0; t <= n + 3; t++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        lat = (d == 1) ? 3 : 1;
        idx = t - lat;
        ev  = (idx >= 0 && idx < n) ? acc_q[idx] : 1'b0;
        v   = (d == 1) ? bus1.rd_valid : bus0.rd_valid;
        dat = (d == 1) ? bus1.rd_data : bus0.rd_data;
        check($sformatf("%s_valid%0d_t%0d", tag, d, t), 64'(v), 64'(ev));
        if (ev) check($sformatf("%s_data%0d_r%0d", tag, d, idx), dat, exp_q[idx]);
      end
      if (t < n) begin
        rdn = rdn_last && (t == n - 1);
        acc_q.push_back(st_m >= 2);
        exp_q.push_back(mread(rq[t]));
        clear_inputs();
        bus0.rd_en = 1; bus0.rd_addr = 10'(rq[t]); bus0.rd_done = rdn;
        model_cycle(1'b0, 0, 64'd0, 0, 1'b0, 1'b1, rdn);
      end else begin
        clear_inputs();
      end
    end
    rq.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1; clear_inputs();
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  logic [63:0] exp0;

  initial begin
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state0", 64'(bus0.state), 64'd0);
    check("rst_len0", 64'(bus0.byte_length), 64'd0);
    check("rst_err0", 64'(bus0.error), 64'd0);
    check("rst_valid0", 64'(bus0.rd_valid), 64'd0);
    check("rst_data0", bus0.rd_data, 64'd0);
    check("rst_valid1", 64'(bus1.rd_valid), 64'd0);
    check("rst_data1", bus1.rd_data, 64'd0);
    rst = 0;

    // Preload every word so any later read has a known expectation.
    for (int i = 0; i < 512; i++) op(1, 2 * i, {$urandom, $urandom}, 8, 0, 0);
    op(0, 0, 0, 0, 1, 0);
    settle("fill");
    op(0, 0, 0, 0, 0, 1);
    settle("fill_drop");

    // Nominal fill and unaligned read.
    op(1, 0, 64'hA0A1_A2A3_B0B1_B2B3, 8, 0, 0);
    op(1, 2, 64'hC0C1_C2C3_D0D1_D2D3, 8, 0, 0);
    op(1, 4, 64'hE0E1_E2E3_F0F1_F2F3, 5, 0, 0);
    op(0, 0, 0, 0, 1, 0);
    settle("nom");
    check("nom_len_const", 64'(bus0.byte_length), 64'd21);
    check("nom_state_const", 64'(bus0.state), 64'd2);
    rq.push_back(1);
    read_burst("nom_rd", 0);
    check("nom_rd_const", bus0.rd_data, 64'hB0B1_B2B3_C0C1_C2C3);
    settle("nom_reading");
    op(0, 0, 0, 0, 0, 1);
    settle("nom_empty");

    // Wrap-around plus random writes with clamped byte counts, then wr_en+wr_done.
    op(1, 1023, 64'h1111_1111_2222_2222, 8, 0, 0);
    for (int j = 0; j < 6; j++)
      op(1, int'($urandom_range(0, 1022)), {$urandom, $urandom}, int'($urandom_range(0, 15)), 0, 0);
    op(1, int'($urandom_range(0, 1023)), {$urandom, $urandom}, 3, 1, 0);
    settle("wrap");
    rq.push_back(1023);
    rq.push_back(0);
    for (int j = 0; j < 4; j++) rq.push_back(int'($urandom_range(0, 1023)));
    read_burst("wrap_rd", 1);
    settle("wrap_done");

    // Protocol errors.
    rq.push_back(5);
    read_burst("err_rd_empty", 0);
    settle("err_rd");
    check("err_sticky0", 64'(bus0.error), 64'd1);
    op(0, 0, 0, 0, 1, 0);
    op(1, 100, {$urandom, $urandom}, 8, 0, 0);
    settle("err_wr_ready");
    rq.push_back(100);
    read_burst("err_mem_kept", 0);
    op(0, 0, 0, 0, 0, 1);
    pulse_reset();
    settle("err_cleared");

    // wr_done alone in EMPTY.
    op(0, 0, 0, 0, 1, 0);
    settle("done_empty");
    check("done_empty_len", 64'(bus0.byte_length), 64'd0);
    op(0, 0, 0, 0, 0, 1);

    // Pipelined back-to-back reads at 0, 2, 4.
    op(1, 0, {$urandom, $urandom}, 8, 0, 0);
    op(1, 2, {$urandom, $urandom}, 8, 0, 0);
    op(1, 4, {$urandom, $urandom}, 8, 1, 0);
    settle("pipe");
    rq.push_back(0);
    rq.push_back(2);
    rq.push_back(4);
    read_burst("pipe_rd", 1);
    settle("pipe_done");

    // Reset one cycle after rd_en: the buffered DUT must never show rd_valid.
    op(0, 0, 0, 0, 1, 0);
    settle("mid_ready");
    @(negedge clk);
    exp0 = mread(0);
    bus0.rd_en = 1; bus0.rd_addr = 0;
    @(negedge clk);
    clear_inputs();
    rst = 1;
    check("mid_valid0", 64'(bus0.rd_valid), 64'd1);
    check("mid_data0", bus0.rd_data, exp0);
    check("mid_valid1", 64'(bus1.rd_valid), 64'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mid_quiet0_%0d", i), 64'(bus0.rd_valid), 64'd0);
      check($sformatf("mid_quiet1_%0d", i), 64'(bus1.rd_valid), 64'd0);
    end
    check("mid_rdata0", bus0.rd_data, 64'd0);
    check("mid_rdata1", bus1.rd_data, 64'd0);
    settle("mid_empty");
    op(0, 0, 0, 0, 1, 0);
    rq.push_back(0);
    rq.push_back(2);
    read_burst("mid_kept", 1);
    settle("mid_kept_done");

    // Saturation from a forced near-max length.
    op(1, 10, {$urandom, $urandom}, 8, 0, 0);
    settle("sat_fill");
    @(negedge clk);
    force dut0.len_q = 33'h1_FFFF_FFFC;
    force dut1.len_q = 33'h1_FFFF_FFFC;
    #1;
    release dut0.len_q;
    release dut1.len_q;
    len_m = 64'h1_FFFF_FFFC;
    op(1, 12, {$urandom, $urandom}, 8, 0, 0);
    settle("sat");
    check("sat_const", 64'(bus0.byte_length), MAXL);
    op(1, 14, {$urandom, $urandom}, 15, 1, 0);
    settle("sat_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
